// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and state type for the four-channel TDM transmitter.
package tdm_pkg;
  localparam int N_CH = 4;
  localparam int ADDR_W = 2;
  typedef enum logic {IDLE, RUN} tdm_state_t;
endpackage

// File: rtl/slot_timer.sv
// slot_timer: per-slot dwell counter, pulses slot_end in the last dwell cycle of every slot.
module slot_timer
  import tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic slot_end
);
  localparam logic [7:0] LAST = 8'(SLOT_CYCLES - 1);
  logic [7:0] dwell;
  assign slot_end = run && dwell == LAST;
  always_ff @(posedge clk) begin
    if (rst || clr) dwell <= 8'd0;
    else if (run) dwell <= slot_end ? 8'd0 : dwell + 8'd1;
  end
endmodule

// File: rtl/tdm_mux4.sv
// tdm_mux4: snapshots four channel bits per frame and sends them serially with slot address.
module tdm_mux4
  import tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH-1:0]   ch_in,
  output logic              dout,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              frame_start
);
  tdm_state_t state, state_d;
  logic [ADDR_W-1:0] slot;
  logic [N_CH-1:0] snap;
  logic slot_end, frame_end, capture, first;
  slot_timer #(.SLOT_CYCLES(SLOT_CYCLES)) u_timer (
    .clk,
    .rst,
    .clr(state == IDLE),
    .run(state == RUN),
    .slot_end
  );
  assign frame_end = slot_end && slot == ADDR_W'(N_CH - 1);
  // A new snapshot is taken either when leaving IDLE or back-to-back at a frame boundary.
  always_comb begin
    capture = en && (state == IDLE || frame_end);
    state_d = capture ? RUN : (frame_end ? IDLE : state);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      slot  <= '0;
      snap  <= '0;
      first <= 1'b0;
    end else begin
      state <= state_d;
      first <= capture;
      if (capture) snap <= ch_in;
      if (slot_end) slot <= slot + 1'b1;
    end
  end
  assign valid = state == RUN;
  assign addr = slot;
  assign dout = valid & snap[slot];
  assign frame_start = first;
endmodule

// File: tb/tb_tdm_mux4.sv
// tb_tdm_mux4: scoreboard bench for tdm_mux4 with SLOT_CYCLES=2 and SLOT_CYCLES=1 instances.
module tb_tdm_mux4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, en1 = 1'b0;
  logic [3:0] ch = '0, ch1 = '0;
  logic dout, valid, fs, dout1, valid1, fs1;
  logic [1:0] addr, addr1;
  int total = 0, bad = 0;
  logic [3:0] q0[$], q1[$], wq[$];
  logic lb_on = 1'b0, pv = 1'b0;
  logic [1:0] pa = '0;
  logic [3:0] rx = '0;
  logic [3:0] w;

  always #5 clk = ~clk;

  tdm_mux4 #(.SLOT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_in(ch),
    .dout(dout), .addr(addr), .valid(valid), .frame_start(fs)
  );
  tdm_mux4 #(.SLOT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .ch_in(ch1),
    .dout(dout1), .addr(addr1), .valid(valid1), .frame_start(fs1)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected entries are {frame_start, dout, addr}, one per valid cycle.
  task automatic push_frame(input int d, input logic [3:0] wd, input int sc, input int n);
    int cnt;
    cnt = 0;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < sc; k++) begin
        logic [3:0] e;
        e = {(s == 0 && k == 0), wd[s], 2'(s)};
        if (cnt < n) begin
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        cnt++;
      end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut_unexpected_valid: got addr=%0d dout=%b fs=%b expected no output", addr, dout, fs);
      end else check("dut_slot", 8'({fs, dout, addr}), 8'(q0.pop_front()));
    end else check("dut_idle", 8'({fs, dout, addr}), 8'd0);
  end

  always @(negedge clk) begin
    if (valid1) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1_unexpected_valid: got addr=%0d dout=%b fs=%b expected no output", addr1, dout1, fs1);
      end else check("dut1_slot", 8'({fs1, dout1, addr1}), 8'(q1.pop_front()));
    end else check("dut1_idle", 8'({fs1, dout1, addr1}), 8'd0);
  end

  // Loopback demux: registered capture on valid, word complete once slot 3 ends.
  always @(posedge clk) begin
    if (valid) rx[addr] <= dout;
    pv <= valid;
    pa <= addr;
  end

  always @(negedge clk) begin
    if (lb_on && pv && pa == 2'd3 && !(valid && addr == 2'd3)) begin
      if (wq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL loopback_extra: got word %b expected none", rx);
      end else check("loopback_word", 8'(rx), 8'(wq.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(2);
    @(negedge clk);
    check("reset_outputs", 8'({valid, fs, dout, addr}), 8'd0);
    rst = 1'b0;
    // Reset while RUN at slot 2.
    ch = 4'b1111;
    en = 1'b1;
    push_frame(0, 4'b1111, 2, 5);
    tick();
    en = 1'b0;
    tick(4);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_frame", 8'({valid, fs, dout, addr}), 8'd0);
    rst = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_stays_idle", 8'({valid, fs, dout, addr}), 8'd0);
    // Back-to-back frames, channel change mid-frame is deferred to the next snapshot.
    ch = 4'b1010;
    en = 1'b1;
    push_frame(0, 4'b1010, 2, 8);
    push_frame(0, 4'b0101, 2, 8);
    tick();
    @(negedge clk);
    check("first_valid_latency", 8'({valid, fs}), 8'b11);
    tick(2);
    ch = 4'b0101;
    tick(7);
    en = 1'b0;
    tick(7);
    @(negedge clk);
    check("after_two_frames", 8'(valid), 8'd0);
    // One-cycle en pulse, then restart from the single idle cycle.
    ch = 4'b0011;
    en = 1'b1;
    push_frame(0, 4'b0011, 2, 8);
    tick();
    en = 1'b0;
    ch = 4'b1111;
    tick(8);
    @(negedge clk);
    check("pulse_gap", 8'(valid), 8'd0);
    ch = 4'b1100;
    en = 1'b1;
    push_frame(0, 4'b1100, 2, 8);
    tick();
    en = 1'b0;
    @(negedge clk);
    check("restart_after_gap", 8'({valid, fs}), 8'b11);
    tick(8);
    @(negedge clk);
    check("restart_done", 8'(valid), 8'd0);
    // SLOT_CYCLES=1: slot advances every clock.
    ch1 = 4'b1111;
    en1 = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(1, 4'b1111, 1, 4);
    tick();
    tick(11);
    en1 = 1'b0;
    tick();
    @(negedge clk);
    check("sc1_end", 8'(valid1), 8'd0);
    // Loopback over three random frames.
    lb_on = 1'b1;
    w = 4'($urandom_range(0, 15));
    ch = w;
    en = 1'b1;
    push_frame(0, w, 2, 8);
    wq.push_back(w);
    tick();
    w = 4'($urandom_range(0, 15));
    ch = w;
    push_frame(0, w, 2, 8);
    wq.push_back(w);
    tick(8);
    w = 4'($urandom_range(0, 15));
    ch = w;
    push_frame(0, w, 2, 8);
    wq.push_back(w);
    tick(8);
    en = 1'b0;
    tick(10);
    lb_on = 1'b0;
    check("q0_drained", 8'(q0.size()), 8'd0);
    check("q1_drained", 8'(q1.size()), 8'd0);
    check("words_drained", 8'(wq.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tdm_mux4.md
# tdm_mux4

Four-channel time-division multiplexer: the transmit end of the lab's 1-to-4 demultiplexer link. It snapshots four parallel channel bits once per frame, then drives them serially on `dout` with the matching 2-bit slot address on `addr`. A downstream `lab32`-style demux that receives `dout`/`addr` reconstructs the four channels. Frames are coherent: all four slots of one frame come from a single snapshot.

## Interface
Parameters:
- `SLOT_CYCLES`, default 4: clock cycles per slot; legal range 1..255.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run request; level-sensitive.
- `ch_in`  in  4  parallel channel bits; bit i is transmitted in slot i.
- `dout`  out  1  serial data of the current slot.
- `addr`  out  2  current slot index, 0..3.
- `valid`  out  1  high while `dout`/`addr` carry frame data.
- `frame_start`  out  1  high for exactly the first cycle of each frame (slot 0, dwell 0).

## Operation
- Reset values: `dout`=0, `addr`=0, `valid`=0, `frame_start`=0; state IDLE; dwell counter 0; snapshot register 0.
- States:
  - IDLE:
    - all outputs 0.
    - `en`=1 sampled: capture `ch_in` into `snap`, set slot=0 and dwell=0, go to RUN.
  - RUN:
    - `valid`=1, `addr`=slot, `dout`=`snap[slot]`.
    - dwell increments each cycle.
    - When dwell is `SLOT_CYCLES`-1: dwell returns to 0 and slot increments.
  - End of frame (slot 3, dwell `SLOT_CYCLES`-1):
    - `en`=1: recapture `ch_in`, slot goes to 0 (wraps), stay in RUN. There is no gap between frames.
    - `en`=0: go to IDLE.
- `en` dropping mid-frame never truncates the frame: the current frame completes, then the block idles.
- `ch_in` changes are ignored except on the capture cycle.
- `rst` mid-frame aborts at once; the next cycle shows reset values. Reset has priority over all other events.
- Arithmetic:
  - slot is 2 bits and wraps naturally 3→0.
  - dwell counter is 8 bits and compares against `SLOT_CYCLES`-1.
  - With `SLOT_CYCLES`=1 every cycle advances the slot.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: `en` sampled high in IDLE at edge N gives the first `valid`/`frame_start` cycle after edge N.
- Frame length: exactly 4×`SLOT_CYCLES` cycles.
- `addr` and `dout` change only at slot boundaries; they are stable for `SLOT_CYCLES` consecutive cycles.
- `frame_start` and `valid` rise in the same cycle; `frame_start` repeats every 4×`SLOT_CYCLES` cycles while `en` stays high.
- After the last slot with `en`=0, `valid` falls the next cycle. Earliest restart: `en` sampled in that IDLE cycle gives `valid` one cycle later (1-cycle gap).

## Structure
- Package `tdm_pkg`:
  - constants `N_CH`=4 and `ADDR_W`=2.
  - state enum `tdm_state_t` {IDLE, RUN}.
- Sub-module `slot_timer`:
  - dwell counter parameterised by `SLOT_CYCLES`.
  - inputs: `clk`, `rst`, `clr`, `run`.
  - output: `slot_end` pulse in the last dwell cycle.
- The top holds the FSM, the slot counter and the snapshot register.

## Test plan
(`SLOT_CYCLES`=2 unless stated)
- Reset while RUN at slot 2 → next cycle `valid`=0, `addr`=0, `dout`=0, `frame_start`=0; the block stays idle with `en`=0.
- `ch_in`=4'b1010, `en` held 1 → `valid` one cycle after `en` is sampled. Expected sequence:
  - `addr` 0,0,1,1,2,2,3,3
  - `dout` 0,0,1,1,0,0,1,1
  - `frame_start` only on the first cycle.
- `en` held 1, `ch_in` changed to 4'b0101 during slot 1 → current frame is unchanged; next frame (no gap, `frame_start` again) sends `dout` 1,1,0,0,1,1,0,0.
- `en` pulsed high for one cycle → exactly one full 8-cycle frame, then `valid`=0. `en` reasserted in the following idle cycle → new frame after exactly a 1-cycle gap.
- `SLOT_CYCLES`=1, `ch_in`=4'b1111, `en`=1 → `addr` cycles 0,1,2,3,0… every clock, `dout`=1 continuously, `frame_start` every 4th cycle.
- Loopback into the 1-to-4 demux (registered capture on `valid`) over 3 random frames → the received 4-bit words equal the snapshots.
